// File: rtl/hc595_pkg.sv
// Shared constants for the 74HC595 receive-side model: default frame geometry,
// field offsets within a frame and the error-counter ceiling.
package hc595_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int SEG_W_DEF  = 8;
  localparam int CNT_W_DEF  = 5;

  // Frame layout: segment byte in the upper bits, digit select below it.
  localparam int SEL_W_DEF   = DATA_W_DEF - SEG_W_DEF;
  localparam int SEG_LSB_DEF = SEL_W_DEF;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/hc595_rx_if.sv
// Serial pin bundle of a 74HC595 chain: data, shift clock, storage clock and
// active-low output enable. The driver side owns the pins; the receiver samples them.
interface hc595_rx_if;
  logic ds;
  logic shcp;
  logic stcp;
  logic oe;

  modport master (output ds, shcp, stcp, oe);
  modport slave  (input  ds, shcp, stcp, oe);
endinterface

// File: rtl/hc595_edge_sync.sv
// Two-flop synchronizer with a third flop for rising-edge detection.
// RST_VAL sets the reset level of every flop except prev, which always resets to 0.
module hc595_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d_in};
    prev_d = sync_q[1];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/hc595_rx.sv
// Receive-side model of a cascaded 74HC595 chain. Optional segment/digit
// decode of the latched word is enabled with HC595_RX_SEG_DECODE_EN.
module hc595_rx
  import hc595_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEG_W  = SEG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  hc595_rx_if.slave         sif,
  output logic [DATA_W-1:0] q_out,
  output logic              latch_pulse,
  output logic              frame_err,
  output logic [7:0]        err_cnt
`ifdef HC595_RX_SEG_DECODE_EN
  ,
  output logic [SEG_W-1:0]        seg_n,
  output logic [DATA_W-SEG_W-1:0] sel,
  output logic [2:0]              digit_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SEG_W >= DATA_W || DATA_W > (1 << CNT_W) - 1) begin : g_bad_cfg
    $error("hc595_rx: SEG_W must be below DATA_W and DATA_W must fit the shift counter");
  end

  logic ds_s, shcp_rise, stcp_rise, oe_s;
  logic ds_rise_unused, oe_rise_unused, shcp_lvl_unused, stcp_lvl_unused;

  hc595_edge_sync #(.RST_VAL(1'b0)) u_ds_sync (
    .clk(sys_clk), .rst(sys_rst), .d_in(sif.ds),   .level(ds_s),            .rise(ds_rise_unused));
  hc595_edge_sync #(.RST_VAL(1'b0)) u_shcp_sync (
    .clk(sys_clk), .rst(sys_rst), .d_in(sif.shcp), .level(shcp_lvl_unused), .rise(shcp_rise));
  hc595_edge_sync #(.RST_VAL(1'b0)) u_stcp_sync (
    .clk(sys_clk), .rst(sys_rst), .d_in(sif.stcp), .level(stcp_lvl_unused), .rise(stcp_rise));
  // Output enable comes out of reset inactive (high), so q_out stays blanked.
  hc595_edge_sync #(.RST_VAL(1'b1)) u_oe_sync (
    .clk(sys_clk), .rst(sys_rst), .d_in(sif.oe),   .level(oe_s),            .rise(oe_rise_unused));

  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [DATA_W-1:0] storage_q,   storage_d;
  logic [DATA_W-1:0] q_out_q,     q_out_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic              latch_q,     latch_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    shreg_d     = shreg_q;
    storage_d   = storage_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    latch_d     = stcp_rise;
    frame_err_d = 1'b0;

    if (shcp_rise) begin
      shreg_d = {shreg_q[DATA_W-2:0], ds_s};
      if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // A coincident shift still lands in shreg; storage takes the pre-shift word
    // and the frame check uses the pre-shift count, as on a real 595.
    if (stcp_rise) begin
      storage_d   = shreg_q;
      frame_err_d = (bit_cnt_q != CNT_W'(DATA_W));
      bit_cnt_d   = shcp_rise ? CNT_W'(1) : '0;
      if (frame_err_d && err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end

    // Built from storage_d so the latched word appears with latch_pulse.
    q_out_d = oe_s ? '0 : storage_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg_q     <= '0;
      storage_q   <= '0;
      q_out_q     <= '0;
      bit_cnt_q   <= '0;
      latch_q     <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      shreg_q     <= shreg_d;
      storage_q   <= storage_d;
      q_out_q     <= q_out_d;
      bit_cnt_q   <= bit_cnt_d;
      latch_q     <= latch_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign q_out       = q_out_q;
  assign latch_pulse = latch_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;

`ifdef HC595_RX_SEG_DECODE_EN
  localparam int SEL_W = DATA_W - SEG_W;

  // Index of the single set bit, or 7 when zero or several bits are set.
  function automatic logic [2:0] onehot_idx(input logic [SEL_W-1:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    if ($countones(v) == 1) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  logic [SEG_W-1:0] seg_n_q, seg_n_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [2:0]       idx_q,   idx_d;

  always_comb begin
    seg_n_d = seg_n_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    if (stcp_rise) begin
      seg_n_d = storage_d[DATA_W-1 -: SEG_W];
      sel_d   = storage_d[SEL_W-1:0];
      idx_d   = onehot_idx(storage_d[SEL_W-1:0]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      seg_n_q <= '0;
      sel_q   <= '0;
      idx_q   <= 3'd7;
    end else begin
      seg_n_q <= seg_n_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign sel       = sel_q;
  assign digit_idx = idx_q;
`endif

endmodule
